// File: rtl/tft_pkg.sv
// Shared types for the TFT draw scheduler: FSM encoding, RGB565 pixel,
// rectangle command record and default panel geometry.
package tft_pkg;

  localparam int unsigned SCREEN_W_DEF = 240;
  localparam int unsigned SCREEN_H_DEF = 320;

  typedef enum logic [2:0] {
    ST_RST_WAIT,
    ST_INIT_ISSUE,
    ST_INIT_RUN,
    ST_IDLE,
    ST_DRAW_ISSUE,
    ST_DRAW_RUN
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    rgb565_t     color;
    logic [15:0] xstart;
    logic [15:0] xend;
    logic [15:0] ystart;
    logic [15:0] yend;
  } rect_t;

  function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found searching upward from ptr+1, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] grant
);

  logic found;

  // Outer loop walks priority distance, inner loop finds the matching slot,
  // so every select index is an elaboration-time constant.
  always_comb begin
    // NOTE: every combinationally written signal gets a default before any branch, so no latch is inferred.
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (((int'(ptr) + k) % NREQ) == j)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tft_draw_sched.sv
// Front-end scheduler for the ILI9341 controller: runs init, then shares the draw
// port between NREQ requesters round-robin. Define TFT_DRAW_SCHED_CLIP_EN to clip commands.
module tft_draw_sched
  import tft_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      ack,
  input  logic [16*NREQ-1:0]   req_color,
  input  logic [16*NREQ-1:0]   req_xstart,
  input  logic [16*NREQ-1:0]   req_xend,
  input  logic [16*NREQ-1:0]   req_ystart,
  input  logic [16*NREQ-1:0]   req_yend,
  input  logic                 reinit,
  output logic                 tft_init,
  output logic                 tft_draw,
  input  logic                 tft_busy,
  output logic [15:0]          tft_color,
  output logic [15:0]          tft_xstart,
  output logic [15:0]          tft_xend,
  output logic [15:0]          tft_ystart,
  output logic [15:0]          tft_yend,
  output logic                 ready,
  output logic [2:0]           owner
);

  if (NREQ < 1 || NREQ > 8 || SCREEN_W < 1 || SCREEN_W > 65536 ||
      SCREEN_H < 1 || SCREEN_H > 65536) begin : g_bad_cfg
    $error("tft_draw_sched: unsupported parameter set");
  end

  state_t          state, state_n;
  logic            reinit_pend;
  logic [2:0]      rr_ptr;
  logic [2:0]      owner_q;
  rect_t           cmd_q;
  rect_t           sel_raw, sel;
  logic [NREQ-1:0] grant;
  logic [2:0]      gnt_idx;
  logic            drop;
  logic            take;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    sel_raw = '0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_idx        = 3'(i);
        sel_raw.color  = rgb565_t'(req_color[16*i +: 16]);
        sel_raw.xstart = req_xstart[16*i +: 16];
        sel_raw.xend   = req_xend[16*i +: 16];
        sel_raw.ystart = req_ystart[16*i +: 16];
        sel_raw.yend   = req_yend[16*i +: 16];
      end
    end
  end

`ifdef TFT_DRAW_SCHED_CLIP_EN
  localparam logic [15:0] X_MAX = 16'(SCREEN_W - 1);
  localparam logic [15:0] Y_MAX = 16'(SCREEN_H - 1);

  // Start coordinates are checked against the raw window, ends after clamping.
  always_comb begin
    sel      = sel_raw;
    sel.xend = clamp16(sel_raw.xend, X_MAX);
    sel.yend = clamp16(sel_raw.yend, Y_MAX);
    drop     = (sel_raw.xstart > X_MAX) || (sel_raw.ystart > Y_MAX) ||
               (sel.xstart > sel.xend)  || (sel.ystart > sel.yend);
  end
`else
  assign sel  = sel_raw;
  assign drop = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    tft_init = 1'b0;
    tft_draw = 1'b0;
    ready    = 1'b0;
    ack      = '0;
    take     = 1'b0;
    case (state)
      ST_RST_WAIT:   if (!tft_busy) state_n = ST_INIT_ISSUE;
      ST_INIT_ISSUE: begin
        tft_init = 1'b1;
        if (tft_busy) state_n = ST_INIT_RUN;
      end
      ST_INIT_RUN:   if (!tft_busy) state_n = ST_IDLE;
      ST_IDLE: begin
        ready = 1'b1;
        if (reinit_pend) begin
          state_n = ST_INIT_ISSUE;
        end else if (|req) begin
          take = 1'b1;
          ack  = grant;
          if (!drop) state_n = ST_DRAW_ISSUE;
        end
      end
      ST_DRAW_ISSUE: begin
        tft_draw = 1'b1;
        if (tft_busy) state_n = ST_DRAW_RUN;
      end
      ST_DRAW_RUN:   if (!tft_busy) state_n = ST_IDLE;
      default:       state_n = ST_RST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state       <= ST_RST_WAIT;
      reinit_pend <= 1'b0;
      rr_ptr      <= 3'(NREQ - 1);
      owner_q     <= '0;
      cmd_q       <= '0;
    end else begin
      state <= state_n;
      // Entering init consumes any pending reinit, including one arriving now.
      if (state_n == ST_INIT_ISSUE && state != ST_INIT_ISSUE) reinit_pend <= 1'b0;
      else if (reinit)                                        reinit_pend <= 1'b1;
      if (take) begin
        rr_ptr <= gnt_idx;
        if (!drop) begin
          owner_q <= gnt_idx;
          cmd_q   <= sel;
        end
      end
    end
  end

  assign tft_color  = cmd_q.color;
  assign tft_xstart = cmd_q.xstart;
  assign tft_xend   = cmd_q.xend;
  assign tft_ystart = cmd_q.ystart;
  assign tft_yend   = cmd_q.yend;
  assign owner      = owner_q;

endmodule

// File: tb/tb_tft_draw_sched.sv
// Scoreboard bench for tft_draw_sched with a behavioural busy model of the
// ILI9341 controller; expected draws are queued at stimulus time.
module tb_tft_draw_sched;
  import tft_pkg::*;

  localparam int NREQ     = 2;
  localparam int BUSY_LAT = 2;
  localparam int RUN_LEN  = 6;

  typedef struct {
    logic [2:0] owner;
    rect_t      r;
    int         inits;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   ack;
  logic [16*NREQ-1:0] req_color, req_xstart, req_xend, req_ystart, req_yend;
  logic              reinit;
  logic              tft_init, tft_draw;
  logic              tft_busy = 1'b0;
  logic [15:0]       tft_color, tft_xstart, tft_xend, tft_ystart, tft_yend;
  logic              ready;
  logic [2:0]        owner;

  always #5 clk = ~clk;

  tft_draw_sched #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .req_color  (req_color),
    .req_xstart (req_xstart),
    .req_xend   (req_xend),
    .req_ystart (req_ystart),
    .req_yend   (req_yend),
    .reinit     (reinit),
    .tft_init   (tft_init),
    .tft_draw   (tft_draw),
    .tft_busy   (tft_busy),
    .tft_color  (tft_color),
    .tft_xstart (tft_xstart),
    .tft_xend   (tft_xend),
    .tft_ystart (tft_ystart),
    .tft_yend   (tft_yend),
    .ready      (ready),
    .owner      (owner)
  );

  // Controller model: samples a strobe only when idle, raises busy BUSY_LAT
  // cycles later and holds it for RUN_LEN cycles.
  int   m_lat = 0;
  int   m_run = 0;
  logic m_draw_op = 1'b0;
  logic ev_draw = 1'b0;
  int   init_cnt = 0;
  int   draw_cnt = 0;

  always @(posedge clk) begin
    ev_draw <= 1'b0;
    if (m_lat > 0) begin
      m_lat <= m_lat - 1;
      if (m_lat == 1) begin
        tft_busy <= 1'b1;
        m_run    <= RUN_LEN;
      end
    end else if (tft_busy) begin
      m_run <= m_run - 1;
      if (m_run == 1) tft_busy <= 1'b0;
    end else if (tft_init || tft_draw) begin
      m_lat     <= BUSY_LAT;
      m_draw_op <= !tft_init;
      if (tft_init) init_cnt <= init_cnt + 1;
      else begin
        draw_cnt <= draw_cnt + 1;
        ev_draw  <= 1'b1;
      end
    end
  end

  int    total = 0;
  int    bad   = 0;
  rect_t rq0[$];
  rect_t rq1[$];
  exp_t  exp_q[$];
  rect_t cur_exp = '0;
  int    rst_epoch = 0;
  int    hold_epoch = -1;
  logic [NREQ-1:0] s_ack;
  logic  s_ready, s_init, s_draw, s_busy, s_ev;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rect_t mk(input logic [15:0] c, input logic [15:0] xs, input logic [15:0] xe,
                               input logic [15:0] ys, input logic [15:0] ye);
    rect_t r;
    r.color  = rgb565_t'(c);
    r.xstart = xs;
    r.xend   = xe;
    r.ystart = ys;
    r.yend   = ye;
    return r;
  endfunction

  function automatic rect_t dut_rect();
    rect_t r;
    r.color  = rgb565_t'(tft_color);
    r.xstart = tft_xstart;
    r.xend   = tft_xend;
    r.ystart = tft_ystart;
    r.yend   = tft_yend;
    return r;
  endfunction

  // What the controller should receive for a command, and whether it is dropped.
  function automatic rect_t model_rect(input rect_t r, output logic drop);
    rect_t m;
    m    = r;
    drop = 1'b0;
`ifdef TFT_DRAW_SCHED_CLIP_EN
    if (m.xend > 16'd239) m.xend = 16'd239;
    if (m.yend > 16'd319) m.yend = 16'd319;
    drop = (r.xstart >= 16'd240) || (r.ystart >= 16'd320) ||
           (m.xstart > m.xend) || (m.ystart > m.yend);
`endif
    return m;
  endfunction

  task automatic drive();
    rect_t a, b;
    a = '0;
    b = '0;
    if (rq0.size() > 0) a = rq0[0];
    if (rq1.size() > 0) b = rq1[0];
    req        = {rq1.size() > 0, rq0.size() > 0};
    req_color  = {b.color, a.color};
    req_xstart = {b.xstart, a.xstart};
    req_xend   = {b.xend, a.xend};
    req_ystart = {b.ystart, a.ystart};
    req_yend   = {b.yend, a.yend};
  endtask

  task automatic push_cmd(input int i, input rect_t r);
    if (i == 0) rq0.push_back(r);
    else        rq1.push_back(r);
    drive();
  endtask

  task automatic expect_draw(input logic [2:0] who, input rect_t r, input int inits);
    exp_t e;
    logic drop;
    e.owner = who;
    e.r     = model_rect(r, drop);
    e.inits = inits;
    if (!drop) exp_q.push_back(e);
  endtask

  // One clock: observe and score at the falling edge, then retire acked
  // commands just after the rising edge so req stays stable across it.
  task automatic tick();
    exp_t  e;
    rect_t tmp;
    @(negedge clk);
    s_ack   = ack;
    s_ready = ready;
    s_init  = tft_init;
    s_draw  = tft_draw;
    s_busy  = tft_busy;
    s_ev    = ev_draw;
    if (ack != '0) begin
      check("ack_onehot", 96'($onehot(ack)), 96'd1);
      check("ack_in_idle", 96'(ready), 96'd1);
      check("ack_has_req", 96'(ack & ~req), 96'd0);
    end
    if (ev_draw) begin
      if (exp_q.size() == 0) begin
        check("unexpected_draw", 96'(dut_rect()), 96'd0);
      end else begin
        e = exp_q.pop_front();
        check("draw_owner", 96'(owner), 96'(e.owner));
        check("draw_rect", 96'(dut_rect()), 96'(e.r));
        check("inits_before_draw", 96'(init_cnt), 96'(e.inits));
        cur_exp    = e.r;
        hold_epoch = rst_epoch;
      end
    end else if (tft_busy && m_draw_op && hold_epoch == rst_epoch) begin
      check("draw_hold", 96'(dut_rect()), 96'(cur_exp));
    end
    @(posedge clk);
    #1;
    if (s_ack[0] && rq0.size() > 0) tmp = rq0.pop_front();
    if (s_ack[1] && rq1.size() > 0) tmp = rq1.pop_front();
    drive();
  endtask

  task automatic wait_draw_start(input string tag);
    int n;
    n = 0;
    s_ev = 1'b0;
    while (!s_ev && n < 200) begin
      tick();
      n++;
    end
    if (!s_ev) check(tag, 96'd0, 96'd1);
  endtask

  task automatic wait_quiet(input string tag);
    int   n;
    logic q;
    n = 0;
    q = 1'b0;
    while (!q && n < 600) begin
      tick();
      n++;
      q = (rq0.size() == 0) && (rq1.size() == 0) && (exp_q.size() == 0) && s_ready && !s_busy;
    end
    if (!q) check(tag, 96'd0, 96'd1);
  endtask

  int   n, d0;
  logic seen_busy, chk_drop, early, seen_low, viol;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    reinit = 1'b0;
    drive();
    repeat (3) tick();
    check("rst_init", 96'(s_init), 96'd0);
    check("rst_draw", 96'(s_draw), 96'd0);
    check("rst_ack", 96'(s_ack), 96'd0);
    check("rst_ready", 96'(s_ready), 96'd0);
    check("rst_owner", 96'(owner), 96'd0);
    check("rst_rect", 96'(dut_rect()), 96'd0);

    // Power-up init: strobe held until busy, ready only once busy falls.
    rst = 1'b0;
    n = 0; seen_busy = 1'b0; chk_drop = 1'b0; early = 1'b0;
    while (!s_ready && n < 60) begin
      tick();
      n++;
      if (chk_drop) begin
        check("init_drop_after_busy", 96'(s_init), 96'd0);
        chk_drop = 1'b0;
      end
      if (s_busy && !seen_busy) begin
        seen_busy = 1'b1;
        check("init_held_until_busy", 96'(s_init), 96'd1);
        chk_drop = 1'b1;
      end
      if (s_draw) early = 1'b1;
    end
    check("init_ready", 96'(s_ready), 96'd1);
    check("ready_after_busy_fall", 96'(seen_busy && !s_busy), 96'd1);
    check("no_draw_before_ready", 96'(early), 96'd0);
    check("init_count", 96'(init_cnt), 96'd1);

    // Both requesters at once: 0 then 1.
    push_cmd(0, mk(16'hF800, 16'd0, 16'd9, 16'd0, 16'd9));
    push_cmd(1, mk(16'h07E0, 16'd10, 16'd19, 16'd20, 16'd29));
    expect_draw(3'd0, mk(16'hF800, 16'd0, 16'd9, 16'd0, 16'd9), 1);
    expect_draw(3'd1, mk(16'h07E0, 16'd10, 16'd19, 16'd20, 16'd29), 1);
    wait_quiet("timeout_pair");

    // Continuous requests from both: 0,1,0,1.
    push_cmd(0, mk(16'h001F, 16'd1, 16'd2, 16'd3, 16'd4));
    push_cmd(0, mk(16'h1234, 16'd5, 16'd6, 16'd7, 16'd8));
    push_cmd(1, mk(16'hABCD, 16'd100, 16'd200, 16'd100, 16'd300));
    push_cmd(1, mk(16'h5555, 16'd0, 16'd239, 16'd0, 16'd319));
    expect_draw(3'd0, mk(16'h001F, 16'd1, 16'd2, 16'd3, 16'd4), 1);
    expect_draw(3'd1, mk(16'hABCD, 16'd100, 16'd200, 16'd100, 16'd300), 1);
    expect_draw(3'd0, mk(16'h1234, 16'd5, 16'd6, 16'd7, 16'd8), 1);
    expect_draw(3'd1, mk(16'h5555, 16'd0, 16'd239, 16'd0, 16'd319), 1);
    wait_quiet("timeout_rr4");

    // reinit during req0's draw with req1 waiting: init runs first.
    push_cmd(0, mk(16'hAAAA, 16'd30, 16'd40, 16'd50, 16'd60));
    expect_draw(3'd0, mk(16'hAAAA, 16'd30, 16'd40, 16'd50, 16'd60), 1);
    wait_draw_start("timeout_reinit_draw");
    push_cmd(1, mk(16'hBBBB, 16'd70, 16'd80, 16'd90, 16'd99));
    expect_draw(3'd1, mk(16'hBBBB, 16'd70, 16'd80, 16'd90, 16'd99), 2);
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    wait_quiet("timeout_reinit");
    check("reinit_count", 96'(init_cnt), 96'd2);

    // Reset while the controller goes busy with a draw.
    push_cmd(0, mk(16'hCCCC, 16'd11, 16'd22, 16'd33, 16'd44));
    expect_draw(3'd0, mk(16'hCCCC, 16'd11, 16'd22, 16'd33, 16'd44), 2);
    wait_draw_start("timeout_rst_draw");
    rst = 1'b1;
    rst_epoch++;
    tick();
    tick();
    check("midrst_draw", 96'(s_draw), 96'd0);
    check("midrst_init", 96'(s_init), 96'd0);
    check("midrst_ready", 96'(s_ready), 96'd0);
    check("midrst_rect", 96'(dut_rect()), 96'd0);
    rst = 1'b0;
    n = 0; seen_low = 1'b0; viol = 1'b0; s_init = 1'b0;
    while (!s_init && n < 60) begin
      tick();
      n++;
      if (s_init && !seen_low) viol = 1'b1;
      if (!s_busy) seen_low = 1'b1;
    end
    check("reinit_after_rst", 96'(s_init), 96'd1);
    check("init_waits_busy_low", 96'(viol), 96'd0);

    // Pointer is back to NREQ-1 after reset, so requester 0 wins first.
    push_cmd(1, mk(16'h0F0F, 16'd1, 16'd1, 16'd1, 16'd1));
    push_cmd(0, mk(16'hF0F0, 16'd2, 16'd2, 16'd2, 16'd2));
    expect_draw(3'd0, mk(16'hF0F0, 16'd2, 16'd2, 16'd2, 16'd2), 3);
    expect_draw(3'd1, mk(16'h0F0F, 16'd1, 16'd1, 16'd1, 16'd1), 3);
    wait_quiet("timeout_post_rst");
    check("init_count_post_rst", 96'(init_cnt), 96'd3);

    // Off-screen window: dropped with clipping, forwarded verbatim without.
    d0 = draw_cnt;
    push_cmd(0, mk(16'h7777, 16'd250, 16'd300, 16'd0, 16'd10));
    expect_draw(3'd0, mk(16'h7777, 16'd250, 16'd300, 16'd0, 16'd10), 3);
    n = 0;
    while (rq0.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    check("offscreen_acked", 96'(rq0.size()), 96'd0);
    repeat (12) tick();
`ifdef TFT_DRAW_SCHED_CLIP_EN
    check("offscreen_no_draw", 96'(draw_cnt), 96'(d0));
`else
    check("offscreen_drawn", 96'(draw_cnt), 96'(d0 + 1));
`endif
    wait_quiet("timeout_offscreen");

    // Oversized right edge: clipped to 239 or passed as 500.
    push_cmd(0, mk(16'h3333, 16'd10, 16'd500, 16'd5, 16'd6));
    expect_draw(3'd0, mk(16'h3333, 16'd10, 16'd500, 16'd5, 16'd6), 3);
    wait_quiet("timeout_clip");

    check("scoreboard_drained", 96'(exp_q.size()), 96'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
